// File: rtl/conway_sequencer.sv
// conway_sequencer: control sequencer for the Conway grid memory.
// Runs a DATA_SIZE-bit serial load, then steps generations either on demand
// (STEP) or from a reloadable free-running timer, counting generations.
// Optional generation limit with a HALT state: define CONWAY_GEN_LIMIT_EN.
module conway_sequencer #(
    parameter int DATA_SIZE = 64,
    parameter int GEN_WIDTH = 16,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LOAD_START,
    input  logic                 SERIAL_VALID,
    input  logic                 SERIAL_DATA,
    input  logic                 RUN_EN,
    input  logic                 FREE_RUN,
    input  logic                 STEP,
    input  logic [DIV_WIDTH-1:0] PERIOD,
`ifdef CONWAY_GEN_LIMIT_EN
    input  logic [GEN_WIDTH-1:0] GEN_LIMIT,
`endif
    output logic                 MEM_SERIAL_IN,
    output logic                 MEM_LOAD_MODE,
    output logic                 MEM_RUN_MODE,
    output logic                 LOAD_DONE,
    output logic                 BUSY,
    output logic                 HALTED,
    output logic [GEN_WIDTH-1:0] GEN_COUNT
);

    localparam int              CNT_W    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

`ifdef CONWAY_GEN_LIMIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READY, S_RUN_WAIT, S_STEP, S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READY, S_RUN_WAIT, S_STEP
    } state_t;
`endif

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DIV_WIDTH-1:0] timer;
    logic [GEN_WIDTH-1:0] gen_count;
    logic                 load_done;
    logic [GEN_WIDTH-1:0] gen_next;

    assign gen_next = gen_count + GEN_WIDTH'(1);

    // Sequencer FSM: load bit counting, step timing and generation counting
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            timer     <= '0;
            gen_count <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (LOAD_START) begin
                // A new load always wins: restarts a load or aborts a run
                state     <= S_LOAD;
                bit_cnt   <= '0;
                gen_count <= '0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_LOAD: begin
                        if (SERIAL_VALID) begin
                            if (bit_cnt == LAST_BIT) begin
                                state     <= S_READY;
                                bit_cnt   <= '0;
                                load_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_READY: begin
                        if (RUN_EN) begin
                            state <= S_RUN_WAIT;
                            timer <= PERIOD;
                        end
                    end
                    S_RUN_WAIT: begin
                        if (!RUN_EN) begin
                            state <= S_READY;
                            timer <= '0;
                        end else if (FREE_RUN) begin
                            if (timer == '0)
                                state <= S_STEP;
                            else
                                timer <= timer - DIV_WIDTH'(1);
                        end else if (STEP) begin
                            state <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        gen_count <= gen_next;
                        timer     <= PERIOD;
`ifdef CONWAY_GEN_LIMIT_EN
                        if ((GEN_LIMIT != '0) && (gen_next == GEN_LIMIT))
                            state <= S_HALT;
                        else
                            state <= S_RUN_WAIT;
`else
                        state <= S_RUN_WAIT;
`endif
                    end
`ifdef CONWAY_GEN_LIMIT_EN
                    S_HALT: ;
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Memory controls decoded from state; load and run modes never overlap
    always_comb begin
        MEM_SERIAL_IN = SERIAL_DATA;
        MEM_LOAD_MODE = (state == S_LOAD) && SERIAL_VALID;
        MEM_RUN_MODE  = (state == S_STEP);
        BUSY          = (state == S_LOAD);
`ifdef CONWAY_GEN_LIMIT_EN
        HALTED        = (state == S_HALT);
`else
        HALTED        = 1'b0;
`endif
        LOAD_DONE     = load_done;
        GEN_COUNT     = gen_count;
    end

endmodule

// File: tb/tb_conway_sequencer.sv
// tb_conway_sequencer: directed self-checking bench for conway_sequencer.
// Inputs are driven just after the falling edge; outputs are sampled 1 ns later.
module tb_conway_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, LOAD_START, SERIAL_VALID, SERIAL_DATA;
    logic        RUN_EN, FREE_RUN, STEP;
    logic [23:0] PERIOD;
`ifdef CONWAY_GEN_LIMIT_EN
    logic [15:0] GEN_LIMIT;
`endif
    logic        MEM_SERIAL_IN, MEM_LOAD_MODE, MEM_RUN_MODE;
    logic        LOAD_DONE, BUSY, HALTED;
    logic [15:0] GEN_COUNT;

    int errors = 0;
    int checks = 0;
    int lm_cnt, done_cnt, ser_bad;
    int pulses, misplaced, first_pulse, load_hi;
    logic step_prev;

    conway_sequencer #(
        .DATA_SIZE(64),
        .GEN_WIDTH(16),
        .DIV_WIDTH(24)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .LOAD_START   (LOAD_START),
        .SERIAL_VALID (SERIAL_VALID),
        .SERIAL_DATA  (SERIAL_DATA),
        .RUN_EN       (RUN_EN),
        .FREE_RUN     (FREE_RUN),
        .STEP         (STEP),
        .PERIOD       (PERIOD),
`ifdef CONWAY_GEN_LIMIT_EN
        .GEN_LIMIT    (GEN_LIMIT),
`endif
        .MEM_SERIAL_IN(MEM_SERIAL_IN),
        .MEM_LOAD_MODE(MEM_LOAD_MODE),
        .MEM_RUN_MODE (MEM_RUN_MODE),
        .LOAD_DONE    (LOAD_DONE),
        .BUSY         (BUSY),
        .HALTED       (HALTED),
        .GEN_COUNT    (GEN_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic sample_load();
        if (MEM_LOAD_MODE) lm_cnt++;
        if (LOAD_DONE) done_cnt++;
        if (MEM_SERIAL_IN !== SERIAL_DATA) ser_bad++;
    endtask

    // Drive n valid bits; with gaps, bit i is preceded by i%4 idle cycles
    task automatic load_bits(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < i % 4; g++) begin
                    SERIAL_VALID = 1'b0;
                    #1;
                    sample_load();
                    tick();
                end
            end
            SERIAL_VALID = 1'b1;
            SERIAL_DATA  = 1'($urandom_range(0, 1));
            #1;
            sample_load();
            tick();
        end
        SERIAL_VALID = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; LOAD_START = 1'b0; SERIAL_VALID = 1'b1; SERIAL_DATA = 1'b1;
        RUN_EN = 1'b1; FREE_RUN = 1'b1; STEP = 1'b1; PERIOD = 24'd3;
`ifdef CONWAY_GEN_LIMIT_EN
        GEN_LIMIT = 16'd0;
`endif
        // Reset state
        tick(); tick(); #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_halted", HALTED, 0);
        chk("rst_load_mode", MEM_LOAD_MODE, 0);
        chk("rst_run_mode", MEM_RUN_MODE, 0);
        chk("rst_load_done", LOAD_DONE, 0);
        chk("rst_gen_count", GEN_COUNT, 0);
        chk("rst_serial_in_hi", MEM_SERIAL_IN, 1);
        SERIAL_DATA = 1'b0; #1;
        chk("rst_serial_in_lo", MEM_SERIAL_IN, 0);

        // IDLE ignores run and serial controls
        RESET = 1'b0; STEP = 1'b0;
        tick(); tick(); #1;
        chk("idle_run_mode", MEM_RUN_MODE, 0);
        chk("idle_load_mode", MEM_LOAD_MODE, 0);

        // Load 64 bits with 0..3 idle gaps
        SERIAL_VALID = 1'b0; RUN_EN = 1'b0; FREE_RUN = 1'b0;
        LOAD_START = 1'b1; tick(); LOAD_START = 1'b0; #1;
        chk("load_busy", BUSY, 1);
        lm_cnt = 0; done_cnt = 0; ser_bad = 0;
        load_bits(64, 1'b1);
        #1;
        chk("load_mode_cycles", lm_cnt, 64);
        chk("load_done_early", done_cnt, 0);
        chk("load_serial_follow", ser_bad, 0);
        chk("load_done_pulse", LOAD_DONE, 1);
        chk("load_ready_busy", BUSY, 0);
        tick(); #1;
        chk("load_done_single", LOAD_DONE, 0);

        // Restart after 10 bits; completion only after 64 post-restart bits
        LOAD_START = 1'b1; tick(); LOAD_START = 1'b0;
        load_bits(10, 1'b0);
        LOAD_START = 1'b1; tick(); LOAD_START = 1'b0; #1;
        chk("restart_busy", BUSY, 1);
        lm_cnt = 0; done_cnt = 0;
        load_bits(64, 1'b1);
        #1;
        chk("restart_mode_cycles", lm_cnt, 64);
        chk("restart_done_early", done_cnt, 0);
        chk("restart_done_pulse", LOAD_DONE, 1);
        chk("restart_busy_low", BUSY, 0);
        tick();

        // Free run, PERIOD=3: steps at cycles 5,10,...,30
        PERIOD = 24'd3; FREE_RUN = 1'b1; RUN_EN = 1'b1;
        pulses = 0; misplaced = 0; first_pulse = -1; load_hi = 0;
        for (int c = 0; c < 31; c++) begin
            SERIAL_VALID = c[0];
            #1;
            if (MEM_RUN_MODE) begin
                pulses++;
                if (first_pulse < 0) first_pulse = c;
                if (c % 5 != 0) misplaced++;
            end
            if (MEM_LOAD_MODE) load_hi++;
            tick();
        end
        SERIAL_VALID = 1'b0; #1;
        chk("free_pulses", pulses, 6);
        chk("free_first_pulse", first_pulse, 5);
        chk("free_spacing", misplaced, 0);
        chk("free_no_load", load_hi, 0);
        chk("free_gen_count", GEN_COUNT, 6);
        RUN_EN = 1'b0;
        tick(); #1;
        chk("pause_run_mode", MEM_RUN_MODE, 0);
        chk("pause_gen_hold", GEN_COUNT, 6);
        tick();

        // Free run, PERIOD=0: a step every 2 cycles
        PERIOD = 24'd0; RUN_EN = 1'b1;
        pulses = 0; misplaced = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (MEM_RUN_MODE) begin
                pulses++;
                if (c == 0 || c % 2 != 0) misplaced++;
            end
            tick();
        end
        #1;
        chk("p0_pulses", pulses, 3);
        chk("p0_spacing", misplaced, 0);
        chk("p0_step_state", MEM_RUN_MODE, 1);
        chk("p0_gen_count", GEN_COUNT, 9);
        RUN_EN = 1'b0;
        tick(); tick(); #1;
        chk("p0_stop_run_mode", MEM_RUN_MODE, 0);
        chk("p0_stop_gen_count", GEN_COUNT, 10);
        tick();

        // Manual steps: three single-cycle STEP pulses, SERIAL_VALID toggling
        FREE_RUN = 1'b0; RUN_EN = 1'b1; PERIOD = 24'd3;
        pulses = 0; misplaced = 0; load_hi = 0; step_prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            STEP = (c == 3 || c == 8 || c == 14);
            SERIAL_VALID = c[0];
            #1;
            if (MEM_RUN_MODE) begin
                pulses++;
                if (!step_prev) misplaced++;
            end
            if (MEM_LOAD_MODE) load_hi++;
            step_prev = STEP;
            tick();
        end
        STEP = 1'b0; SERIAL_VALID = 1'b0; #1;
        chk("man_pulses", pulses, 3);
        chk("man_latency", misplaced, 0);
        chk("man_no_load", load_hi, 0);
        chk("man_gen_count", GEN_COUNT, 13);
        tick();

        // STEP held high steps every 2 cycles
        pulses = 0; misplaced = 0;
        for (int c = 0; c < 6; c++) begin
            STEP = 1'b1;
            #1;
            if (MEM_RUN_MODE) begin
                pulses++;
                if (c % 2 == 0) misplaced++;
            end
            tick();
        end
        STEP = 1'b0; #1;
        chk("held_pulses", pulses, 3);
        chk("held_spacing", misplaced, 0);
        chk("held_gen_count", GEN_COUNT, 16);

        // LOAD_START aborts the run and clears GEN_COUNT
        LOAD_START = 1'b1; tick(); LOAD_START = 1'b0; #1;
        chk("abort_busy", BUSY, 1);
        chk("abort_gen_clear", GEN_COUNT, 0);
        chk("abort_run_mode", MEM_RUN_MODE, 0);
        RUN_EN = 1'b0;
        load_bits(64, 1'b0);
        #1;
        chk("reload_done", LOAD_DONE, 1);
        tick();

        // Reset during RUN_WAIT
        PERIOD = 24'd0; FREE_RUN = 1'b1; RUN_EN = 1'b1;
        tick(); tick(); tick(); #1;
        chk("pre_reset_gen", GEN_COUNT, 1);
        chk("pre_reset_run_wait", MEM_RUN_MODE, 0);
        RESET = 1'b1; SERIAL_VALID = 1'b1;
        tick(); #1;
        chk("rstrun_busy", BUSY, 0);
        chk("rstrun_run_mode", MEM_RUN_MODE, 0);
        chk("rstrun_load_mode", MEM_LOAD_MODE, 0);
        chk("rstrun_gen_count", GEN_COUNT, 0);
        RESET = 1'b0;
        tick(); #1;
        chk("rstrun_idle_run", MEM_RUN_MODE, 0);

        // Reset during LOAD
        SERIAL_VALID = 1'b0; RUN_EN = 1'b0;
        LOAD_START = 1'b1; tick(); LOAD_START = 1'b0;
        load_bits(5, 1'b0);
        RESET = 1'b1; SERIAL_VALID = 1'b1;
        tick(); #1;
        chk("rstload_busy", BUSY, 0);
        chk("rstload_load_mode", MEM_LOAD_MODE, 0);
        chk("rstload_load_done", LOAD_DONE, 0);
        RESET = 1'b0; SERIAL_VALID = 1'b0;
        tick();

        // Fresh load after reset needs all 64 bits
        LOAD_START = 1'b1; tick(); LOAD_START = 1'b0;
        lm_cnt = 0; done_cnt = 0;
        load_bits(63, 1'b0);
        #1;
        chk("bit63_still_busy", BUSY, 1);
        chk("bit63_no_done", done_cnt, 0);
        load_bits(1, 1'b0);
        #1;
        chk("bit64_done", LOAD_DONE, 1);

`ifdef CONWAY_GEN_LIMIT_EN
        // Generation limit 4 with PERIOD=0, then HALT until LOAD_START
        GEN_LIMIT = 16'd4; PERIOD = 24'd0; FREE_RUN = 1'b1; RUN_EN = 1'b1;
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (MEM_RUN_MODE) pulses++;
            tick();
        end
        #1;
        chk("limit_pulses", pulses, 4);
        chk("limit_halted", HALTED, 1);
        chk("limit_gen_count", GEN_COUNT, 4);
        chk("limit_run_mode", MEM_RUN_MODE, 0);
        LOAD_START = 1'b1; tick(); LOAD_START = 1'b0; #1;
        chk("limit_clear_halted", HALTED, 0);
        chk("limit_clear_gen", GEN_COUNT, 0);
        chk("limit_busy", BUSY, 1);
`else
        // Without the limit build, runs never halt
        PERIOD = 24'd0; FREE_RUN = 1'b1; RUN_EN = 1'b1;
        for (int c = 0; c < 14; c++) tick();
        #1;
        chk("nolimit_halted", HALTED, 0);
        chk("nolimit_gen_count", GEN_COUNT, 6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
